mem_wb_stage: RTL and testbench

MEM-stage consumer of the EX/MEM pipeline register. It performs the data-memory access over a request/grant/response handshake and stalls the pipeline while an access is outstanding. It also registers the results into the MEM/WB pipeline register, including the final write-back data. It sits between the EX/MEM register and the register-file write port, and drives the hazard unit's memory-stall input.

---
 rtl/mem_wb_stage_pkg.sv | 17 +
 rtl/mem_wb_stage_dmem_access_fsm.sv | 134 +++++++++++++
 rtl/mem_wb_stage.sv | 110 +++++++++++
 tb/tb_mem_wb_stage.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared pipeline definitions for the MEM stage: data width, write-back select
// encodings and the data-memory access state enum.
package mem_wb_stage_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

    typedef enum logic [1:0] {
        MS_IDLE = 2'b00,
        MS_REQ  = 2'b01,
        MS_RESP = 2'b10
    } mem_state_e;

endpackage

// File: rtl/mem_wb_stage_dmem_access_fsm.sv
// Data-memory access sequencer: request/grant/response handshake, request
// latches, wait counter with timeout abort, and the per-access done strobe.
module dmem_access_fsm
    import mem_wb_stage_pkg::*;
#(
    parameter int TIMEOUT = 16
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_rd,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_gnt,
    input  logic              i_rvalid,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_req,
    output logic              o_we,
    output logic [DATA_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_done,
    output logic [DATA_W-1:0] o_load_data,
    output logic              o_err
);

    mem_state_e        r_state;
    mem_state_e        w_next;
    logic [7:0]        r_cnt;
    logic              r_we;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_err;

    logic              w_mem_op;
    logic              w_is_wr;
    logic              w_timeout;
    logic              w_req;
    logic              w_latch;
    logic              w_abort;

    assign w_mem_op  = i_rd | i_wr;
    assign w_is_wr   = i_wr & ~i_rd;
    assign w_timeout = (r_cnt == 8'(TIMEOUT - 1));

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next      = r_state;
        w_req       = 1'b0;
        o_we        = 1'b0;
        o_addr      = '0;
        o_wdata     = '0;
        o_done      = 1'b0;
        o_load_data = '0;
        w_latch     = 1'b0;
        w_abort     = 1'b0;

        case (r_state)
            MS_IDLE: begin
                if (!w_mem_op) begin
                    o_done = 1'b1;
                end else begin
                    w_req   = 1'b1;
                    o_we    = w_is_wr;
                    o_addr  = i_addr;
                    o_wdata = i_wdata;
                    w_latch = 1'b1;
                    if (i_gnt) begin
                        if (w_is_wr) o_done = 1'b1;
                        else         w_next = MS_RESP;
                    end else begin
                        w_next = MS_REQ;
                    end
                end
            end
            MS_REQ: begin
                w_req   = 1'b1;
                o_we    = r_we;
                o_addr  = r_addr;
                o_wdata = r_wdata;
                if (i_gnt) begin
                    if (r_we) begin
                        o_done = 1'b1;
                        w_next = MS_IDLE;
                    end else begin
                        w_next = MS_RESP;
                    end
                end
            end
            MS_RESP: begin
                // Response is only looked for here, so an rvalid in the grant cycle is dropped.
                if (i_rvalid) begin
                    o_done      = 1'b1;
                    o_load_data = i_rdata;
                    w_next      = MS_IDLE;
                end
            end
            default: w_next = MS_IDLE;
        endcase

        if (r_state != MS_IDLE && !o_done && w_timeout) begin
            o_done      = 1'b1;
            o_load_data = '0;
            w_abort     = 1'b1;
            w_next      = MS_IDLE;
        end
    end

    // The IDLE-cycle request is combinational, so it must be gated while reset is held.
    assign o_req = w_req & reset;
    assign o_err = r_err;

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= MS_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_abort;
            r_cnt   <= (r_state == MS_IDLE) ? 8'd0 : r_cnt + 8'd1;
            if (w_latch) begin
                r_we    <= w_is_wr;
                r_addr  <= i_addr;
                r_wdata <= i_wdata;
            end
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage with MEM/WB pipeline register and data-memory handshake.
// Optional MEM_WB_STORE_FWD_EN forwards MEM/WB write-back data into store data.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int TIMEOUT = 16
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              EX_MEM_MemRead,
    input  logic              EX_MEM_MemWrite,
    input  logic              EX_MEM_RegWrite,
    input  logic [1:0]        EX_MEM_MemtoReg,
    input  logic [DATA_W-1:0] EX_MEM_ALUOut,
    input  logic [DATA_W-1:0] EX_MEM_WriteData,
    input  logic [DATA_W-1:0] EX_MEM_PC_add4,
    input  logic [4:0]        EX_MEM_RegWrAddr,
    input  logic [4:0]        EX_MEM_Rt,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              Mem_Stall,
    output logic              Mem_Err,
    output logic              MEM_WB_RegWrite,
    output logic [4:0]        MEM_WB_RegWrAddr,
    output logic [DATA_W-1:0] MEM_WB_WriteData,
    output logic [DATA_W-1:0] MEM_WB_ReadData
);

    logic              r_wb_regwrite;
    logic [4:0]        r_wb_regwraddr;
    logic [DATA_W-1:0] r_wb_writedata;
    logic [DATA_W-1:0] r_wb_readdata;

    logic              w_done;
    logic [DATA_W-1:0] w_load_data;
    logic [DATA_W-1:0] w_store_data;
    logic [DATA_W-1:0] w_wb_data;

`ifdef MEM_WB_STORE_FWD_EN
    assign w_store_data = (r_wb_regwrite && r_wb_regwraddr == EX_MEM_Rt && EX_MEM_Rt != 5'd0)
                        ? r_wb_writedata : EX_MEM_WriteData;
`else
    logic w_unused_rt;
    assign w_unused_rt  = ^EX_MEM_Rt;
    assign w_store_data = EX_MEM_WriteData;
`endif

    dmem_access_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_fsm (
        .clk         (clk),
        .reset       (reset),
        .i_rd        (EX_MEM_MemRead),
        .i_wr        (EX_MEM_MemWrite),
        .i_addr      (EX_MEM_ALUOut),
        .i_wdata     (w_store_data),
        .i_gnt       (dmem_gnt),
        .i_rvalid    (dmem_rvalid),
        .i_rdata     (dmem_rdata),
        .o_req       (dmem_req),
        .o_we        (dmem_we),
        .o_addr      (dmem_addr),
        .o_wdata     (dmem_wdata),
        .o_done      (w_done),
        .o_load_data (w_load_data),
        .o_err       (Mem_Err)
    );

    always_comb begin
        case (EX_MEM_MemtoReg)
            WB_SEL_MEM: w_wb_data = w_load_data;
            WB_SEL_PC4: w_wb_data = EX_MEM_PC_add4;
            default:    w_wb_data = EX_MEM_ALUOut;
        endcase
    end

    assign Mem_Stall = (EX_MEM_MemRead | EX_MEM_MemWrite) & ~w_done;

    // A stalled cycle writes a bubble so the register file never sees a half-finished access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wb_regwrite  <= 1'b0;
            r_wb_regwraddr <= '0;
            r_wb_writedata <= '0;
            r_wb_readdata  <= '0;
        end else if (w_done) begin
            r_wb_regwrite  <= EX_MEM_RegWrite;
            r_wb_regwraddr <= EX_MEM_RegWrAddr;
            r_wb_writedata <= w_wb_data;
            r_wb_readdata  <= w_load_data;
        end else begin
            r_wb_regwrite  <= 1'b0;
            r_wb_regwraddr <= '0;
            r_wb_writedata <= '0;
            r_wb_readdata  <= '0;
        end
    end

    assign MEM_WB_RegWrite  = r_wb_regwrite;
    assign MEM_WB_RegWrAddr = r_wb_regwraddr;
    assign MEM_WB_WriteData = r_wb_writedata;
    assign MEM_WB_ReadData  = r_wb_readdata;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: expected MEM/WB results are queued when an
// instruction is issued and compared when the DUT drops Mem_Stall.
module tb_mem_wb_stage;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_RegWrite;
    logic [1:0]  EX_MEM_MemtoReg;
    logic [31:0] EX_MEM_ALUOut, EX_MEM_WriteData, EX_MEM_PC_add4;
    logic [4:0]  EX_MEM_RegWrAddr, EX_MEM_Rt;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        Mem_Stall, Mem_Err, MEM_WB_RegWrite;
    logic [4:0]  MEM_WB_RegWrAddr;
    logic [31:0] MEM_WB_WriteData, MEM_WB_ReadData;

    typedef struct {
        logic        rw;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_wb_stage #(.TIMEOUT(TO)) dut (
        .clk              (clk),
        .reset            (reset),
        .EX_MEM_MemRead   (EX_MEM_MemRead),
        .EX_MEM_MemWrite  (EX_MEM_MemWrite),
        .EX_MEM_RegWrite  (EX_MEM_RegWrite),
        .EX_MEM_MemtoReg  (EX_MEM_MemtoReg),
        .EX_MEM_ALUOut    (EX_MEM_ALUOut),
        .EX_MEM_WriteData (EX_MEM_WriteData),
        .EX_MEM_PC_add4   (EX_MEM_PC_add4),
        .EX_MEM_RegWrAddr (EX_MEM_RegWrAddr),
        .EX_MEM_Rt        (EX_MEM_Rt),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_gnt         (dmem_gnt),
        .dmem_rvalid      (dmem_rvalid),
        .dmem_rdata       (dmem_rdata),
        .Mem_Stall        (Mem_Stall),
        .Mem_Err          (Mem_Err),
        .MEM_WB_RegWrite  (MEM_WB_RegWrite),
        .MEM_WB_RegWrAddr (MEM_WB_RegWrAddr),
        .MEM_WB_WriteData (MEM_WB_WriteData),
        .MEM_WB_ReadData  (MEM_WB_ReadData)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_nop();
        EX_MEM_MemRead   = 1'b0;
        EX_MEM_MemWrite  = 1'b0;
        EX_MEM_RegWrite  = 1'b0;
        EX_MEM_MemtoReg  = 2'b00;
        EX_MEM_ALUOut    = '0;
        EX_MEM_WriteData = '0;
        EX_MEM_PC_add4   = '0;
        EX_MEM_RegWrAddr = '0;
        EX_MEM_Rt        = '0;
        dmem_gnt         = 1'b0;
        dmem_rvalid      = 1'b0;
        dmem_rdata       = '0;
    endtask

    // Issue one instruction held in EX/MEM until the DUT stops stalling.
    // gnt_cyc / rv_cyc: cycle index of the single grant / rvalid pulse (-1 = never).
    task automatic run_op(input logic rd, input logic wr, input logic rw, input logic [1:0] m2r,
                          input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4,
                          input logic [4:0] waddr, input logic [4:0] rt,
                          input int gnt_cyc, input int rv_cyc,
                          input logic [31:0] rdata, input logic [31:0] bus_wd);
        logic        mem, st, abort, exp_req, seen_done;
        int          gnt_eff, nat, done_c;
        logic [31:0] ld;
        exp_t        e, got_e;

        mem     = rd | wr;
        st      = wr & ~rd;
        gnt_eff = (gnt_cyc < 0) ? 1000 : gnt_cyc;
        if (!mem)                                   nat = 0;
        else if (st)                                nat = gnt_eff;
        else if (gnt_eff < 1000 && rv_cyc > gnt_eff) nat = rv_cyc;
        else                                        nat = 1000;
        abort  = (nat > TO);
        done_c = abort ? TO : nat;
        ld     = (rd && !abort) ? rdata : 32'h0;

        e.rw    = rw;
        e.waddr = waddr;
        e.rdata = ld;
        e.err   = abort;
        case (m2r)
            2'b01:   e.wdata = ld;
            2'b10:   e.wdata = pc4;
            default: e.wdata = alu;
        endcase
        sb_q.push_back(e);

        EX_MEM_MemRead   = rd;
        EX_MEM_MemWrite  = wr;
        EX_MEM_RegWrite  = rw;
        EX_MEM_MemtoReg  = m2r;
        EX_MEM_ALUOut    = alu;
        EX_MEM_WriteData = wd;
        EX_MEM_PC_add4   = pc4;
        EX_MEM_RegWrAddr = waddr;
        EX_MEM_Rt        = rt;

        seen_done = 1'b0;
        for (int c = 0; c <= TO + 4 && !seen_done; c++) begin
            dmem_gnt    = (c == gnt_cyc);
            dmem_rvalid = (c == rv_cyc);
            dmem_rdata  = (c == rv_cyc) ? rdata : 32'hFFFF_FFFF;
            @(negedge clk);
            check("stall", Mem_Stall, (c < done_c));
            exp_req = mem && (c <= gnt_eff) && (c <= done_c);
            check("req", dmem_req, exp_req);
            if (exp_req) begin
                check("addr", dmem_addr, alu);
                check("we", dmem_we, st);
                if (st) check("wdata", dmem_wdata, bus_wd);
            end
            if (c > 0) check("err_during", Mem_Err, 1'b0);
            seen_done = !Mem_Stall;
            @(posedge clk);
            #1;
        end
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        if (!seen_done) check("done_timeout", 32'd0, 32'd1);

        got_e = sb_q.pop_front();
        check("wb_regwrite", MEM_WB_RegWrite, got_e.rw);
        check("wb_regwraddr", MEM_WB_RegWrAddr, got_e.waddr);
        check("wb_writedata", MEM_WB_WriteData, got_e.wdata);
        check("wb_readdata", MEM_WB_ReadData, got_e.rdata);
        check("mem_err", Mem_Err, got_e.err);
    endtask

    // Non-memory bubbles; rv_at injects a stray rvalid that must be ignored.
    task automatic idle(input int n, input int rv_at);
        drive_nop();
        for (int i = 0; i < n; i++) begin
            dmem_rvalid = (i == rv_at);
            dmem_rdata  = 32'h1357_9BDF;
            @(posedge clk);
            #1;
            check("idle_err", Mem_Err, 1'b0);
            check("idle_readdata", MEM_WB_ReadData, 32'h0);
            check("idle_regwrite", MEM_WB_RegWrite, 1'b0);
            check("idle_req", dmem_req, 1'b0);
        end
        dmem_rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        drive_nop();
        reset = 1'b0;
        EX_MEM_MemRead = 1'b1;
        EX_MEM_ALUOut  = 32'h0000_00C0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", dmem_req, 1'b0);
        check("rst_regwrite", MEM_WB_RegWrite, 1'b0);
        check("rst_writedata", MEM_WB_WriteData, 32'h0);
        check("rst_readdata", MEM_WB_ReadData, 32'h0);
        check("rst_regwraddr", MEM_WB_RegWrAddr, 5'd0);
        check("rst_err", Mem_Err, 1'b0);
        drive_nop();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // ALU, PC+4, MemtoReg=11 (treated as ALU)
        run_op(0, 0, 1, 2'b00, 32'h0000_1234, 32'h0, 32'h100, 5'd5, 5'd0, -1, -1, 32'h0, 32'h0);
        run_op(0, 0, 1, 2'b10, 32'h0000_5555, 32'h0, 32'h2004, 5'd31, 5'd0, -1, -1, 32'h0, 32'h0);
        run_op(0, 0, 1, 2'b11, 32'hA5A5_0001, 32'h0, 32'h3008, 5'd12, 5'd0, -1, -1, 32'h0, 32'h0);
        // Store with grant after 2 cycles, then zero-wait store
        run_op(0, 1, 0, 2'b00, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0, 5'd0, 5'd9, 2, -1, 32'h0, 32'hDEAD_BEEF);
        run_op(0, 1, 0, 2'b00, 32'h0000_0044, 32'h0BAD_F00D, 32'h0, 5'd0, 5'd10, 0, -1, 32'h0, 32'h0BAD_F00D);
        // Loads: immediate grant, delayed grant, both MemRead and MemWrite set
        run_op(1, 0, 1, 2'b01, 32'h0000_0080, 32'h0, 32'h0, 5'd7, 5'd0, 0, 3, 32'hCAFE_F00D, 32'h0);
        run_op(1, 0, 1, 2'b00, 32'h0000_0084, 32'h0, 32'h0, 5'd6, 5'd0, 1, 4, 32'h1111_2222, 32'h0);
        run_op(1, 1, 1, 2'b01, 32'h0000_0088, 32'h7777_7777, 32'h0, 5'd4, 5'd0, 0, 2, 32'h3333_4444, 32'h0);
        // Load timeout, late rvalid at cycle 20; then store with no grant
        run_op(1, 0, 1, 2'b01, 32'h0000_0090, 32'h0, 32'h0, 5'd3, 5'd0, 0, -1, 32'h0, 32'h0);
        idle(6, 3);
        run_op(0, 1, 0, 2'b00, 32'h0000_0094, 32'h2468_ACE0, 32'h0, 5'd0, 5'd11, -1, -1, 32'h0, 32'h2468_ACE0);
        idle(2, -1);

        // Reset in the middle of a RESP wait
        EX_MEM_MemRead   = 1'b1;
        EX_MEM_RegWrite  = 1'b1;
        EX_MEM_MemtoReg  = 2'b01;
        EX_MEM_ALUOut    = 32'h0000_00A0;
        EX_MEM_RegWrAddr = 5'd2;
        dmem_gnt         = 1'b1;
        @(posedge clk);
        #1;
        dmem_gnt = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_req", dmem_req, 1'b0);
        check("midrst_regwrite", MEM_WB_RegWrite, 1'b0);
        check("midrst_writedata", MEM_WB_WriteData, 32'h0);
        check("midrst_err", Mem_Err, 1'b0);
        drive_nop();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hEEEE_EEEE;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_err", Mem_Err, 1'b0);
        check("postrst_readdata", MEM_WB_ReadData, 32'h0);
        run_op(1, 0, 1, 2'b01, 32'h0000_00B0, 32'h0, 32'h0, 5'd13, 5'd0, 0, 1, 32'h0F0F_0F0F, 32'h0);

        // Load-to-store pair on r8 with stale store data; r0 never forwards
        run_op(1, 0, 1, 2'b01, 32'h0000_0100, 32'h0, 32'h0, 5'd8, 5'd0, 0, 1, 32'h0000_0055, 32'h0);
`ifdef MEM_WB_STORE_FWD_EN
        run_op(0, 1, 0, 2'b00, 32'h0000_0104, 32'h0, 32'h0, 5'd0, 5'd8, 2, -1, 32'h0, 32'h0000_0055);
`else
        run_op(0, 1, 0, 2'b00, 32'h0000_0104, 32'h0, 32'h0, 5'd0, 5'd8, 2, -1, 32'h0, 32'h0);
`endif
        run_op(1, 0, 1, 2'b01, 32'h0000_0108, 32'h0, 32'h0, 5'd0, 5'd0, 0, 1, 32'h0000_0077, 32'h0);
        run_op(0, 1, 0, 2'b00, 32'h0000_010C, 32'h0000_0011, 32'h0, 5'd0, 5'd0, 1, -1, 32'h0, 32'h0000_0011);

        check("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
